store_buffer: RTL

//  Write-through store buffer between the write-through data cache and data_mem.
//  The cache pushes every store (sw/sh/sb) into an in-order FIFO.
//  The FIFO drains one store at a time to data memory over a req/ack handshake, so cache stores never wait on memory latency.
//  ld_conflict flags loads whose word is still pending, so the pipeline stalls the load instead of reading stale memory.

---
 rtl/store_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// In-order write-through store buffer: the cache pushes stores into a small FIFO that
// drains one entry at a time to data memory over a req/ack handshake. ld_conflict
// flags a load whose word address matches any store still waiting in the buffer.
module store_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [2:0]              st_mode,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic                    ld_conflict,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [2:0]              mem_mode,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    drained
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]    valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [2:0]            mode_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic push, pop;

  // Byte offset within the word never participates in the hazard compare.
  logic unused_ld_lsbs;
  assign unused_ld_lsbs = ^ld_addr[1:0];

  // Handshake decode; ready depends on occupancy only, never on mem_ack.
  always_comb begin
    st_ready = (count_q != CntW'(DEPTH));
    push     = st_valid && st_ready;
    pop      = (state_q == StReq) && mem_ack;
  end

  // Occupancy next-state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM next-state: keep presenting while entries remain, no bubble between stores.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (push || (count_q != '0)) state_d = StReq;
      StReq:  if (pop && (count_d == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state: pointers, occupancy, valid bits and FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
    end
  end

  // Entry payload capture; not reset since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr;
      mode_q[wr_ptr_q] <= st_mode;
      data_q[wr_ptr_q] <= st_data;
    end
  end

  // Memory-side outputs come straight from the head entry.
  always_comb begin
    mem_req   = (state_q == StReq);
    mem_addr  = addr_q[rd_ptr_q];
    mem_mode  = mode_q[rd_ptr_q];
    mem_wdata = data_q[rd_ptr_q];
    count     = count_q;
    empty     = (count_q == '0);
    drained   = empty && (state_q == StIdle);
  end

  // Word-granular hazard check against every still-valid entry (registered state only).
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (addr_q[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
        ld_conflict = 1'b1;
      end
    end
  end

endmodule
